// File: rtl/axi_lite_reg_target.sv
// AXI4-Lite register target: NUM_REGS word registers with byte strobes,
// read-only status mapping, SLVERR on bad accesses and per-register access pulses.
module axi_lite_reg_target #(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter int unsigned          NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           wvalid,
   output logic                           wready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   output logic                           bvalid,
   input  logic                           bready,
   output logic [1:0]                     bresp,
   input  logic                           arvalid,
   output logic                           arready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
   output logic [NUM_REGS-1:0]            write_pulse,
   output logic [NUM_REGS-1:0]            read_pulse
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] status_v;

   w_state_e                w_state_q, w_state_d;
   logic                    aw_got_q, aw_got_d;
   logic                    w_got_q, w_got_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [NUM_REGS-1:0]     write_pulse_q, write_pulse_d;

   r_state_e                r_state_q, r_state_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic                    aw_hs, w_hs, ar_hs;
   logic [ADDR_WIDTH-1:0]   w_addr_eff, w_word, r_word;
   logic [DATA_WIDTH-1:0]   w_data_eff;
   logic [STRB_W-1:0]       w_strb_eff;
   logic [IDX_W-1:0]        w_idx, r_idx;
   logic                    w_in_range, w_ok, r_in_range;

   assign status_v = status_in;

   assign aw_hs = awvalid && awready_q;
   assign w_hs  = wvalid && wready_q;
   assign ar_hs = arvalid && arready_q;

   // Same-cycle handshakes bypass the capture registers so the commit needs no extra cycle.
   assign w_addr_eff = aw_got_q ? awaddr_q : awaddr;
   assign w_data_eff = w_got_q  ? wdata_q  : wdata;
   assign w_strb_eff = w_got_q  ? wstrb_q  : wstrb;

   assign w_word     = w_addr_eff >> LSB;
   assign w_in_range = w_word < ADDR_WIDTH'(NUM_REGS);
   assign w_idx      = w_word[IDX_W-1:0];
   assign w_ok       = w_in_range && !RO_MASK[w_idx];

   assign r_word     = araddr >> LSB;
   assign r_in_range = r_word < ADDR_WIDTH'(NUM_REGS);
   assign r_idx      = r_word[IDX_W-1:0];

   // Write channel: independent AW/W capture, commit when both are held.
   always_comb begin
      w_state_d     = w_state_q;
      aw_got_d      = aw_got_q;
      w_got_d       = w_got_q;
      awaddr_d      = awaddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      awready_d     = awready_q;
      wready_d      = wready_q;
      bvalid_d      = bvalid_q;
      bresp_d       = bresp_q;
      write_pulse_d = '0;
      regs_d        = regs_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_got_d  = 1'b1;
               awaddr_d  = awaddr;
               awready_d = 1'b0;
            end
            if (w_hs) begin
               w_got_d  = 1'b1;
               wdata_d  = wdata;
               wstrb_d  = wstrb;
               wready_d = 1'b0;
            end
            if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
               w_state_d = W_RESP;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               if (w_ok) begin
                  bresp_d       = RESP_OKAY;
                  write_pulse_d = NUM_REGS'(1) << w_idx;
                  for (int b = 0; b < STRB_W; b++) begin
                     if (w_strb_eff[b]) begin
                        regs_d[w_idx][b*8 +: 8] = w_data_eff[b*8 +: 8];
                     end
                  end
               end else begin
                  bresp_d = RESP_SLVERR;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: sample storage (pre-write value) or status on the AR handshake.
   always_comb begin
      r_state_d  = r_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      read_pulse = '0;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               if (r_in_range) begin
                  rdata_d    = RO_MASK[r_idx] ? status_v[r_idx] : regs_q[r_idx];
                  rresp_d    = RESP_OKAY;
                  read_pulse = NUM_REGS'(1) << r_idx;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         R_RESP: begin
            if (rready) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         regs_q        <= '0;
         w_state_q     <= W_IDLE;
         aw_got_q      <= 1'b0;
         w_got_q       <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awready_q     <= 1'b1;
         wready_q      <= 1'b1;
         bvalid_q      <= 1'b0;
         bresp_q       <= RESP_OKAY;
         write_pulse_q <= '0;
         r_state_q     <= R_IDLE;
         arready_q     <= 1'b1;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         rresp_q       <= RESP_OKAY;
      end else begin
         regs_q        <= regs_d;
         w_state_q     <= w_state_d;
         aw_got_q      <= aw_got_d;
         w_got_q       <= w_got_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awready_q     <= awready_d;
         wready_q      <= wready_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         write_pulse_q <= write_pulse_d;
         r_state_q     <= r_state_d;
         arready_q     <= arready_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         rresp_q       <= rresp_d;
      end
   end

   assign awready     = awready_q;
   assign wready      = wready_q;
   assign bvalid      = bvalid_q;
   assign bresp       = bresp_q;
   assign write_pulse = write_pulse_q;
   assign arready     = arready_q;
   assign rvalid      = rvalid_q;
   assign rdata       = rdata_q;
   assign rresp       = rresp_q;
   assign regs_out    = regs_q;

endmodule

// File: doc/axi_lite_reg_target.md
Name: axi_lite_reg_target

Overview:
- Parametrised AXI4-Lite target that exposes NUM_REGS word-wide control/status registers to the Zynq PS general-purpose master.
- Successor to the fixed top-level register hookup. It adds:
  - configurable register count and width
  - byte strobes
  - independent AW/W acceptance
  - per-register read-only (status) mapping
  - SLVERR for bad accesses
  - per-register access pulses for the fabric side
- Sits between the PS M_AXI port and the emulator core control logic.

Parameters:
DATA_WIDTH, 32, register/bus data width in bits; must be 32 or 64.
ADDR_WIDTH, 32, AXI address width.
NUM_REGS, 16, number of word registers; 1..256.
RO_MASK, 0 (NUM_REGS bits), bit i=1 makes register i read-only; reads of it return status_in slice i.

Ports:
clock  in  1  sole clock.
reset  in  1  synchronous, active-high.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
awaddr  in  ADDR_WIDTH  write byte address.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  byte strobes.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
bresp  out  2  00 OKAY, 10 SLVERR.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  ADDR_WIDTH  read byte address.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
rdata  out  DATA_WIDTH  read data.
rresp  out  2  00 OKAY, 10 SLVERR.
regs_out  out  NUM_REGS*DATA_WIDTH  current register contents, register i at slice i.
status_in  in  NUM_REGS*DATA_WIDTH  fabric status values for RO registers.
write_pulse  out  NUM_REGS  one-cycle strobe per successful write.
read_pulse  out  NUM_REGS  one-cycle strobe per accepted read.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - Reset clears all registers, both FSMs, and the captured address/data.
  - After reset: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=00; rdata=0; pulses=0.
  - Reset mid-transaction abandons it with no register update and no response.
- Addressing:
  - Word index = addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
  - Index >= NUM_REGS is out of range.
- Write FSM (W_IDLE, W_RESP):
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
  - Once AW is captured, awready drops; once W is captured, wready drops. The other channel stays ready.
  - In the cycle the second of the two handshakes completes, the write commits on that clock edge.
  - Commit rules:
    - In range and not RO: each byte with its wstrb bit set is updated, other bytes are kept, bresp=00.
    - Out of range or RO: no update, bresp=10.
  - Next cycle: FSM enters W_RESP, bvalid=1, the new value is visible on regs_out, and write_pulse[i]=1 for exactly one cycle (OKAY writes only; wstrb=0 still pulses).
  - W_RESP holds bvalid and bresp until bready. On the bready cycle it returns to W_IDLE, and awready/wready rise the next cycle.
- Read FSM (R_IDLE, R_RESP):
  - R_IDLE: arready=1. The arvalid handshake samples the register (or status_in for RO registers) at that cycle and asserts read_pulse[i] for that same cycle.
  - Next cycle: R_RESP, rvalid=1, arready=0.
  - Out-of-range reads return rdata=0, rresp=10, and no pulse.
  - rdata/rresp are held stable until rready, then the FSM returns to R_IDLE.
- Read/write ordering:
  - Read and write paths are fully concurrent.
  - If a read handshake and a write commit hit the same register in the same cycle, the read returns the pre-write value.
- Read latency is 1 cycle (AR handshake to rvalid).
- Write latency is 1 cycle (last of AW/W to bvalid).
- Throughput: one transaction per 2 cycles per channel with ready held high.

Test Plan:
1. Reset, then AW+W in the same cycle: addr 0x08, data 0xDEADBEEF, wstrb 0xF, bready=1 -> next cycle bvalid=1, bresp=00, regs_out slice 2=0xDEADBEEF, write_pulse=0x0004 for one cycle.
2. W at cycle 0 (data 0x000000AA, wstrb 0x1), AW 0x08 at cycle 3 -> wready low on cycles 1-3, commit at cycle 3, reg2=0xDEADBEAA, bvalid on cycle 4.
3. Read addr 0x08 with rready held low 5 cycles -> rvalid and rdata=0xDEADBEAA held stable 5 cycles, arready=0 until after the rready handshake, read_pulse=0x0004 on the AR cycle only.
4. With RO_MASK bit 3=1 and status_in slice 3=0x12345678: write 0x0C -> bresp=10 and no pulse; read 0x0C -> rdata=0x12345678, rresp=00.
5. Out of range (NUM_REGS=16): write 0x40 -> bresp=10, no register change; read 0x40 -> rdata=0, rresp=10.
6. Write commit of 0x1 to reg0 in the same cycle as an AR handshake on 0x00 (old value 0) -> rdata=0; a following read -> 1. Also: assert reset while bvalid=1 -> bvalid=0 next cycle, all registers 0.
